// File: rtl/set_assoc_lookup_controller.sv
// Tag-store controller for a set-associative single-port array: lookup, fill and invalidate with round-robin victim choice.
// Optional hit/miss counters are built when SET_ASSOC_LOOKUP_STATS_EN is defined.
module set_assoc_lookup_controller #(
  parameter int unsigned TAG_WIDTH_IN_BITS     = 32,
  parameter int unsigned NUM_SET               = 64,
  parameter int unsigned NUM_WAY               = 16,
  parameter int unsigned SET_PTR_WIDTH_IN_BITS = $clog2(NUM_SET),
  parameter int unsigned ENTRY_WIDTH           = TAG_WIDTH_IN_BITS + 1,
  parameter int unsigned WRITE_MASK_LEN        = (ENTRY_WIDTH + 7) / 8
) (
  input  logic                             clk_in,
  input  logic                             reset_in,
  input  logic                             req_valid_in,
  output logic                             req_ready_out,
  input  logic [1:0]                       req_op_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0] req_set_in,
  input  logic [TAG_WIDTH_IN_BITS-1:0]     req_tag_in,
  output logic                             resp_valid_out,
  input  logic                             resp_ready_in,
  output logic                             resp_hit_out,
  output logic [NUM_WAY-1:0]               resp_way_out,
  output logic                             resp_evict_valid_out,
  output logic [TAG_WIDTH_IN_BITS-1:0]     resp_evict_tag_out,
  output logic                             array_access_en_out,
  output logic [WRITE_MASK_LEN-1:0]        array_write_en_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0] array_set_addr_out,
  output logic [NUM_WAY-1:0]               array_way_select_out,
  output logic [ENTRY_WIDTH-1:0]           array_write_entry_out,
  input  logic [ENTRY_WIDTH*NUM_WAY-1:0]   array_read_set_in
`ifdef SET_ASSOC_LOOKUP_STATS_EN
  ,
  output logic [31:0]                      hit_count_out,
  output logic [31:0]                      miss_count_out
`endif
);

  localparam int unsigned WAY_PTR_WIDTH = (NUM_WAY > 1) ? $clog2(NUM_WAY) : 1;

  typedef enum logic [2:0] {IDLE, READ, COMPARE, WRITE, RESP} state_t;

  state_t                             state_q, state_d;
  logic [1:0]                         op_q;
  logic [SET_PTR_WIDTH_IN_BITS-1:0]   set_q;
  logic [TAG_WIDTH_IN_BITS-1:0]       tag_q;
  logic [ENTRY_WIDTH*NUM_WAY-1:0]     read_q;
  logic [NUM_WAY-1:0]                 target_q;
  logic [ENTRY_WIDTH-1:0]             wr_entry_q;
  logic                               resp_hit_q;
  logic [NUM_WAY-1:0]                 resp_way_q;
  logic                               evict_valid_q;
  logic [TAG_WIDTH_IN_BITS-1:0]       evict_tag_q;
  logic [WAY_PTR_WIDTH-1:0]           rr_ptr_q [NUM_SET];

  logic [TAG_WIDTH_IN_BITS-1:0]       way_tag [NUM_WAY];
  logic [NUM_WAY-1:0]                 way_valid;
  logic [NUM_WAY-1:0]                 hit_vec;
  logic                               hit_any, inv_any;
  logic [WAY_PTR_WIDTH-1:0]           hit_idx, inv_idx, victim_idx, rr_cur;
  logic [NUM_WAY-1:0]                 victim_onehot;
  logic                               is_fill, is_inv, use_rr;

  assign is_fill = (op_q == 2'd1);
  assign is_inv  = (op_q == 2'd2);

  for (genvar w = 0; w < NUM_WAY; w++) begin : g_way
    assign way_tag[w]   = read_q[w*ENTRY_WIDTH +: TAG_WIDTH_IN_BITS];
    assign way_valid[w] = read_q[w*ENTRY_WIDTH + TAG_WIDTH_IN_BITS];
    assign hit_vec[w]   = way_valid[w] && (way_tag[w] == tag_q);
  end

  // Scan from the top way down so the lowest matching index is the last one written.
  always_comb begin
    hit_any = 1'b0;
    inv_any = 1'b0;
    hit_idx = '0;
    inv_idx = '0;
    for (int unsigned i = 0; i < NUM_WAY; i++) begin
      if (hit_vec[NUM_WAY-1-i]) begin
        hit_any = 1'b1;
        hit_idx = WAY_PTR_WIDTH'(NUM_WAY-1-i);
      end
      if (!way_valid[NUM_WAY-1-i]) begin
        inv_any = 1'b1;
        inv_idx = WAY_PTR_WIDTH'(NUM_WAY-1-i);
      end
    end
  end

  assign rr_cur        = rr_ptr_q[set_q];
  assign use_rr        = is_fill && !hit_any && !inv_any;
  assign victim_idx    = hit_any ? hit_idx : (inv_any ? inv_idx : rr_cur);
  assign victim_onehot = NUM_WAY'(1) << victim_idx;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d               = state_q;
    req_ready_out         = 1'b0;
    resp_valid_out        = 1'b0;
    array_access_en_out   = 1'b0;
    array_write_en_out    = '0;
    array_set_addr_out    = '0;
    array_way_select_out  = '0;
    array_write_entry_out = '0;
    unique case (state_q)
      IDLE: begin
        req_ready_out = 1'b1;
        if (req_valid_in) begin
          array_access_en_out  = 1'b1;
          array_way_select_out = '1;
          array_set_addr_out   = req_set_in;
          state_d              = READ;
        end
      end
      READ:    state_d = COMPARE;
      COMPARE: state_d = (is_fill || (is_inv && hit_any)) ? WRITE : RESP;
      WRITE: begin
        array_access_en_out   = 1'b1;
        array_write_en_out    = '1;
        array_set_addr_out    = set_q;
        array_way_select_out  = target_q;
        array_write_entry_out = wr_entry_q;
        state_d               = RESP;
      end
      RESP: begin
        resp_valid_out = 1'b1;
        if (resp_ready_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      op_q          <= '0;
      set_q         <= '0;
      tag_q         <= '0;
      read_q        <= '0;
      target_q      <= '0;
      wr_entry_q    <= '0;
      resp_hit_q    <= 1'b0;
      resp_way_q    <= '0;
      evict_valid_q <= 1'b0;
      evict_tag_q   <= '0;
      for (int unsigned s = 0; s < NUM_SET; s++) rr_ptr_q[s] <= '0;
    end else begin
      if (state_q == IDLE && req_valid_in) begin
        op_q  <= req_op_in;
        set_q <= req_set_in;
        tag_q <= req_tag_in;
      end
      if (state_q == READ) read_q <= array_read_set_in;
      if (state_q == COMPARE) begin
        resp_hit_q    <= hit_any;
        target_q      <= victim_onehot;
        resp_way_q    <= (is_fill || hit_any) ? victim_onehot : '0;
        evict_valid_q <= use_rr;
        evict_tag_q   <= use_rr ? way_tag[victim_idx] : '0;
        wr_entry_q    <= is_fill ? {1'b1, tag_q} : {1'b0, way_tag[victim_idx]};
        if (use_rr)
          rr_ptr_q[set_q] <= (rr_cur == WAY_PTR_WIDTH'(NUM_WAY-1)) ? '0 : rr_cur + WAY_PTR_WIDTH'(1);
      end
    end
  end

  assign resp_hit_out         = resp_hit_q;
  assign resp_way_out         = resp_way_q;
  assign resp_evict_valid_out = evict_valid_q;
  assign resp_evict_tag_out   = evict_tag_q;

`ifdef SET_ASSOC_LOOKUP_STATS_EN
  logic [31:0] hit_count_q, miss_count_q;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else if (state_q == RESP && resp_ready_in && !is_fill && !is_inv) begin
      if (resp_hit_q && hit_count_q != '1)   hit_count_q  <= hit_count_q + 32'd1;
      if (!resp_hit_q && miss_count_q != '1) miss_count_q <= miss_count_q + 32'd1;
    end
  end

  assign hit_count_out  = hit_count_q;
  assign miss_count_out = miss_count_q;
`endif

endmodule
